// File: rtl/licao_unidade_controle_pkg.sv
// Shared definitions for the lesson controller: state codes, play modes,
// error policies, menu screen selectors and the Moore output decode.
package licao_unidade_controle_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        MENU_INICIO    = 5'h01,
        MENU_MODO      = 5'h02,
        MENU_POLITICA  = 5'h03,
        PREPARA        = 5'h04,
        INICIO_RODADA  = 5'h05,
        MOSTRA         = 5'h06,
        ESPERA_MOSTRA  = 5'h07,
        PROX_MOSTRA    = 5'h08,
        INICIO_NOTA    = 5'h09,
        ESPERA_NOTA    = 5'h0A,
        TOCA_NOTA      = 5'h0B,
        COMPARA        = 5'h0C,
        PROX_NOTA      = 5'h0D,
        FIM_RODADA     = 5'h0E,
        ERROU          = 5'h0F,
        MOSTRA_ERRO    = 5'h10,
        PERDEU         = 5'h11,
        GANHOU         = 5'h12,
        LIVRE          = 5'h13,
        TOCA_LIVRE     = 5'h14
    } estado_t;

    typedef enum logic [1:0] {
        MODO_PROGRESSIVO = 2'd0,
        MODO_COMPLETO    = 2'd1,
        MODO_DEMO        = 2'd2,
        MODO_LIVRE       = 2'd3
    } modo_t;

    localparam logic [1:0] POL_REPETE_RODADA  = 2'd0;
    localparam logic [1:0] POL_REPETE_ENTRADA = 2'd1;
    localparam logic [1:0] POL_MOSTRA_ERRO    = 2'd2;

    localparam logic [1:0] MENU_SEL_MODO      = 2'd0;
    localparam logic [1:0] MENU_SEL_POLITICA  = 2'd1;
    localparam logic [1:0] MENU_SEL_RESULTADO = 2'd3;

    typedef struct packed {
        logic       zera_intervalo;
        logic       conta_intervalo;
        logic       zera_tempo;
        logic       conta_tempo;
        logic       zera_metro;
        logic       conta_metro;
        logic       registra_nota;
        logic       toca;
        logic       leds_mem;
        logic       ativa_leds;
        logic       vez_jogador;
        logic       inicia_menu;
        logic       ganhou;
        logic       perdeu;
        logic [1:0] menu_sel;
    } ctrl_t;

    // Moore output decode; unused state codes decode to all-zero outputs
    function automatic ctrl_t decodifica(input estado_t e);
        ctrl_t c;
        c = '0;
        case (e)
            MENU_INICIO:   c.inicia_menu = 1'b1;
            MENU_MODO:     c.menu_sel = MENU_SEL_MODO;
            MENU_POLITICA: c.menu_sel = MENU_SEL_POLITICA;
            PREPARA: begin
                c.zera_intervalo = 1'b1;
                c.zera_tempo     = 1'b1;
                c.zera_metro     = 1'b1;
            end
            INICIO_RODADA: c.conta_intervalo = 1'b1;
            MOSTRA:        c.zera_metro = 1'b1;
            ESPERA_MOSTRA, MOSTRA_ERRO: begin
                c.leds_mem    = 1'b1;
                c.ativa_leds  = 1'b1;
                c.conta_metro = 1'b1;
            end
            INICIO_NOTA, PROX_NOTA: c.zera_tempo = 1'b1;
            ESPERA_NOTA: begin
                c.vez_jogador = 1'b1;
                c.conta_tempo = 1'b1;
            end
            TOCA_NOTA: begin
                c.toca          = 1'b1;
                c.ativa_leds    = 1'b1;
                c.registra_nota = 1'b1;
                c.conta_metro   = 1'b1;
            end
            ERROU: begin
                c.zera_tempo = 1'b1;
                c.zera_metro = 1'b1;
            end
            PERDEU: begin
                c.perdeu   = 1'b1;
                c.menu_sel = MENU_SEL_RESULTADO;
            end
            GANHOU: begin
                c.ganhou   = 1'b1;
                c.menu_sel = MENU_SEL_RESULTADO;
            end
            TOCA_LIVRE: begin
                c.toca        = 1'b1;
                c.ativa_leds  = 1'b1;
                c.conta_metro = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/licao_contadores.sv
// Lesson counters: note address, round limit, error count and score.
// Clear wins over increment; error count and score saturate at all-ones.
module licao_contadores #(
    parameter int ADDR_W  = 4,
    parameter int TENT_W  = 2,
    parameter int SCORE_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               end_zera,
    input  logic               end_incr,
    input  logic               rod_carrega,
    input  logic [ADDR_W-1:0]  rod_valor,
    input  logic               rod_incr,
    input  logic               tent_zera,
    input  logic               tent_incr,
    input  logic               pts_zera,
    input  logic               pts_incr,
    output logic [ADDR_W-1:0]  endereco,
    output logic [ADDR_W-1:0]  rodada,
    output logic [TENT_W-1:0]  tentativas,
    output logic [SCORE_W-1:0] pontos
);

    // Note address: the FSM never increments past the round limit, so no wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         endereco <= '0;
        else if (end_zera) endereco <= '0;
        else if (end_incr) endereco <= endereco + 1'b1;
    end

    // Round limit: loaded at game preparation, advanced after each won round
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            rodada <= '0;
        else if (rod_carrega) rodada <= rod_valor;
        else if (rod_incr)    rodada <= rodada + 1'b1;
    end

    // Consecutive errors within the current round, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                              tentativas <= '0;
        else if (tent_zera)                     tentativas <= '0;
        else if (tent_incr && tentativas != '1) tentativas <= tentativas + 1'b1;
    end

    // Correct notes since preparation, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          pontos <= '0;
        else if (pts_zera)                  pontos <= '0;
        else if (pts_incr && pontos != '1)  pontos <= pontos + 1'b1;
    end

endmodule

// File: rtl/licao_unidade_controle.sv
// Lesson controller for the FPGAudio piano: menu, four play modes, error
// policies with bounded retries and scoring. Outputs are registered Moore
// decodes of the next state, so they always match db_estado.
module licao_unidade_controle
    import licao_unidade_controle_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int MAX_TENT = 3,
    parameter int TENT_W   = 2,
    parameter int SCORE_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               press_enter,
    input  logic [1:0]         modo,
    input  logic [1:0]         politica,
    input  logic [ADDR_W-1:0]  comprimento,
    input  logic               fim_intervalo,
    input  logic               fim_mostra,
    input  logic               fim_tempo,
    input  logic               nota_feita,
    input  logic               nota_correta,
    input  logic               tempo_correto,
    output logic [ADDR_W-1:0]  endereco,
    output logic [ADDR_W-1:0]  rodada,
    output logic [TENT_W-1:0]  tentativas,
    output logic [SCORE_W-1:0] pontos,
    output logic               zera_intervalo,
    output logic               conta_intervalo,
    output logic               zera_tempo,
    output logic               conta_tempo,
    output logic               zera_metro,
    output logic               conta_metro,
    output logic               registra_nota,
    output logic               toca,
    output logic               leds_mem,
    output logic               ativa_leds,
    output logic               vez_jogador,
    output logic               inicia_menu,
    output logic [1:0]         menu_sel,
    output logic               ganhou,
    output logic               perdeu,
    output logic [4:0]         db_estado
);

    localparam logic [TENT_W:0] MAX_TENT_V = (TENT_W + 1)'(MAX_TENT);

    estado_t             state_reg, state_next;
    ctrl_t               ctrl_reg;
    modo_t               modo_reg;
    logic [1:0]          politica_reg;
    logic [ADDR_W-1:0]   comprimento_reg;

    logic                lat_modo, lat_pol, lat_comp;
    logic                end_zera, end_incr, rod_carrega, rod_incr;
    logic                tent_zera, tent_incr, pts_zera, pts_incr;
    logic [ADDR_W-1:0]   rod_valor;
    logic [TENT_W:0]     tent_plus;
    logic                sai_demo;

    licao_contadores #(
        .ADDR_W  (ADDR_W),
        .TENT_W  (TENT_W),
        .SCORE_W (SCORE_W)
    ) u_contadores (
        .clock       (clock),
        .reset       (reset),
        .end_zera    (end_zera),
        .end_incr    (end_incr),
        .rod_carrega (rod_carrega),
        .rod_valor   (rod_valor),
        .rod_incr    (rod_incr),
        .tent_zera   (tent_zera),
        .tent_incr   (tent_incr),
        .pts_zera    (pts_zera),
        .pts_incr    (pts_incr),
        .endereco    (endereco),
        .rodada      (rodada),
        .tentativas  (tentativas),
        .pontos      (pontos)
    );

    // Error count after the error being handled, unsaturated for the loss test
    assign tent_plus = {1'b0, tentativas} + 1'b1;

    // Demo mode can be left from anywhere in the display loop
    assign sai_demo = (modo_reg == MODO_DEMO) && press_enter &&
                      (state_reg == INICIO_RODADA || state_reg == MOSTRA ||
                       state_reg == ESPERA_MOSTRA || state_reg == PROX_MOSTRA);

    // Next-state logic plus the counter/config updates applied on leaving a state
    always_comb begin
        state_next  = state_reg;
        lat_modo    = 1'b0;
        lat_pol     = 1'b0;
        lat_comp    = 1'b0;
        end_zera    = 1'b0;
        end_incr    = 1'b0;
        rod_carrega = 1'b0;
        rod_valor   = '0;
        rod_incr    = 1'b0;
        tent_zera   = 1'b0;
        tent_incr   = 1'b0;
        pts_zera    = 1'b0;
        pts_incr    = 1'b0;
        if (sai_demo) begin
            state_next = INICIAL;
        end else begin
            case (state_reg)
                INICIAL:     if (iniciar) state_next = MENU_INICIO;
                MENU_INICIO: state_next = MENU_MODO;
                MENU_MODO: if (press_enter) begin
                    lat_modo   = 1'b1;
                    state_next = MENU_POLITICA;
                end
                MENU_POLITICA: if (press_enter) begin
                    lat_pol    = 1'b1;
                    state_next = PREPARA;
                end
                PREPARA: begin
                    lat_comp    = 1'b1;
                    end_zera    = 1'b1;
                    tent_zera   = 1'b1;
                    pts_zera    = 1'b1;
                    rod_carrega = 1'b1;
                    rod_valor   = (modo_reg == MODO_PROGRESSIVO) ? '0 : comprimento;
                    state_next  = (modo_reg == MODO_LIVRE) ? LIVRE : INICIO_RODADA;
                end
                INICIO_RODADA: begin
                    end_zera = 1'b1;
                    if (fim_intervalo) state_next = MOSTRA;
                end
                MOSTRA: state_next = ESPERA_MOSTRA;
                ESPERA_MOSTRA: if (fim_mostra) begin
                    if (endereco != rodada)         state_next = PROX_MOSTRA;
                    else if (modo_reg == MODO_DEMO) state_next = INICIO_RODADA;
                    else                            state_next = INICIO_NOTA;
                end
                PROX_MOSTRA: begin
                    end_incr   = 1'b1;
                    state_next = MOSTRA;
                end
                INICIO_NOTA: begin
                    end_zera   = 1'b1;
                    state_next = ESPERA_NOTA;
                end
                ESPERA_NOTA: begin
                    if (fim_tempo)       state_next = ERROU;
                    else if (nota_feita) state_next = TOCA_NOTA;
                end
                TOCA_NOTA: if (!nota_feita) state_next = COMPARA;
                COMPARA: begin
                    if (!nota_correta || !tempo_correto) begin
                        state_next = ERROU;
                    end else begin
                        pts_incr   = 1'b1;
                        state_next = (endereco == rodada) ? FIM_RODADA : PROX_NOTA;
                    end
                end
                PROX_NOTA: begin
                    end_incr   = 1'b1;
                    state_next = ESPERA_NOTA;
                end
                FIM_RODADA: begin
                    tent_zera = 1'b1;
                    if (rodada == comprimento_reg) begin
                        state_next = GANHOU;
                    end else begin
                        rod_incr   = 1'b1;
                        state_next = INICIO_RODADA;
                    end
                end
                ERROU: begin
                    tent_incr = 1'b1;
                    if (tent_plus == MAX_TENT_V) begin
                        state_next = PERDEU;
                    end else begin
                        case (politica_reg)
                            POL_REPETE_ENTRADA: state_next = INICIO_NOTA;
                            POL_MOSTRA_ERRO:    state_next = MOSTRA_ERRO;
                            default:            state_next = INICIO_RODADA;
                        endcase
                    end
                end
                MOSTRA_ERRO: if (fim_mostra) state_next = ESPERA_NOTA;
                PERDEU, GANHOU: begin
                    if (iniciar)          state_next = PREPARA;
                    else if (press_enter) state_next = INICIAL;
                end
                LIVRE: begin
                    if (press_enter)     state_next = INICIAL;
                    else if (nota_feita) state_next = TOCA_LIVRE;
                end
                TOCA_LIVRE: if (!nota_feita) state_next = LIVRE;
                default: state_next = INICIAL;
            endcase
        end
    end

    // State register with outputs registered from the next-state decode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= INICIAL;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decodifica(state_next);
        end
    end

    // Game configuration, captured once and held for the whole game
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            modo_reg        <= MODO_PROGRESSIVO;
            politica_reg    <= '0;
            comprimento_reg <= '0;
        end else begin
            if (lat_modo) modo_reg        <= modo_t'(modo);
            if (lat_pol)  politica_reg    <= politica;
            if (lat_comp) comprimento_reg <= comprimento;
        end
    end

    assign zera_intervalo  = ctrl_reg.zera_intervalo;
    assign conta_intervalo = ctrl_reg.conta_intervalo;
    assign zera_tempo      = ctrl_reg.zera_tempo;
    assign conta_tempo     = ctrl_reg.conta_tempo;
    assign zera_metro      = ctrl_reg.zera_metro;
    assign conta_metro     = ctrl_reg.conta_metro;
    assign registra_nota   = ctrl_reg.registra_nota;
    assign toca            = ctrl_reg.toca;
    assign leds_mem        = ctrl_reg.leds_mem;
    assign ativa_leds      = ctrl_reg.ativa_leds;
    assign vez_jogador     = ctrl_reg.vez_jogador;
    assign inicia_menu     = ctrl_reg.inicia_menu;
    assign menu_sel        = ctrl_reg.menu_sel;
    assign ganhou          = ctrl_reg.ganhou;
    assign perdeu          = ctrl_reg.perdeu;
    assign db_estado       = state_reg;

endmodule

// File: tb/tb_licao_unidade_controle.sv
// Directed bench for the lesson controller: menu, progressive win, retry
// loss, show-error policy, timeout priority, async reset, demo and free play.
module tb_licao_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, press_enter = 1'b0;
    logic [1:0] modo = 2'd0, politica = 2'd0;
    logic [3:0] comprimento = 4'd0;
    logic       fim_intervalo = 1'b0, fim_mostra = 1'b0, fim_tempo = 1'b0;
    logic       nota_feita = 1'b0, nota_correta = 1'b0, tempo_correto = 1'b0;
    logic [3:0] endereco, rodada;
    logic [1:0] tentativas;
    logic [7:0] pontos;
    logic       zera_intervalo, conta_intervalo, zera_tempo, conta_tempo;
    logic       zera_metro, conta_metro, registra_nota, toca, leds_mem;
    logic       ativa_leds, vez_jogador, inicia_menu, ganhou, perdeu;
    logic [1:0] menu_sel;
    logic [4:0] db_estado;
    logic [15:0] all_out;

    int checks = 0;
    int errors = 0;

    licao_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .press_enter(press_enter),
        .modo(modo), .politica(politica), .comprimento(comprimento),
        .fim_intervalo(fim_intervalo), .fim_mostra(fim_mostra), .fim_tempo(fim_tempo),
        .nota_feita(nota_feita), .nota_correta(nota_correta), .tempo_correto(tempo_correto),
        .endereco(endereco), .rodada(rodada), .tentativas(tentativas), .pontos(pontos),
        .zera_intervalo(zera_intervalo), .conta_intervalo(conta_intervalo),
        .zera_tempo(zera_tempo), .conta_tempo(conta_tempo),
        .zera_metro(zera_metro), .conta_metro(conta_metro),
        .registra_nota(registra_nota), .toca(toca), .leds_mem(leds_mem),
        .ativa_leds(ativa_leds), .vez_jogador(vez_jogador), .inicia_menu(inicia_menu),
        .menu_sel(menu_sel), .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    assign all_out = {zera_intervalo, conta_intervalo, zera_tempo, conta_tempo,
                      zera_metro, conta_metro, registra_nota, toca, leds_mem,
                      ativa_leds, vez_jogador, inicia_menu, ganhou, perdeu, menu_sel};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From INICIAL through the menu and PREPARA; config inputs are scrambled after capture
    task automatic start_game(input logic [1:0] m, input logic [1:0] p,
                              input logic [3:0] c, input logic [4:0] dest);
        iniciar = 1'b1; step();
        chk("st_menu_inicio", 32'(db_estado), 32'h01);
        chk("inicia_menu", 32'(inicia_menu), 32'd1);
        iniciar = 1'b0; step();
        chk("st_menu_modo", 32'(db_estado), 32'h02);
        chk("menu_sel_modo", 32'(menu_sel), 32'd0);
        modo = m; press_enter = 1'b1; step();
        chk("st_menu_pol", 32'(db_estado), 32'h03);
        chk("menu_sel_pol", 32'(menu_sel), 32'd1);
        modo = m ^ 2'b01; politica = p; comprimento = c; step();
        chk("st_prepara", 32'(db_estado), 32'h04);
        chk("zeras_prepara", 32'({zera_intervalo, zera_tempo, zera_metro}), 32'h7);
        press_enter = 1'b0; politica = p ^ 2'b11; step();
        comprimento = c ^ 4'b0101;
        chk("st_after_prepara", 32'(db_estado), 32'(dest));
        $display("game start modo=%0d politica=%0d comprimento=%0d state=%0h", m, p, c, db_estado);
    endtask

    // From INICIO_RODADA: show notes 0..n, ending in end_state
    task automatic show_round(input int n, input logic [4:0] end_state);
        fim_intervalo = 1'b1; step(); fim_intervalo = 1'b0;
        chk("st_mostra", 32'(db_estado), 32'h06);
        for (int i = 0; i <= n; i++) begin
            step();
            chk("st_espera_mostra", 32'(db_estado), 32'h07);
            chk("show_endereco", 32'(endereco), 32'(i));
            chk("show_leds_mem", 32'(leds_mem), 32'd1);
            chk("show_vez", 32'(vez_jogador), 32'd0);
            fim_mostra = 1'b1; step(); fim_mostra = 1'b0;
            if (i < n) begin
                chk("st_prox_mostra", 32'(db_estado), 32'h08);
                step();
                chk("st_mostra_again", 32'(db_estado), 32'h06);
            end else begin
                chk("st_show_end", 32'(db_estado), 32'(end_state));
            end
        end
        $display("round shown n=%0d state=%0h", n, db_estado);
    endtask

    // In ESPERA_NOTA: press and release one key; returns after COMPARA exits
    task automatic press_note(input logic ok);
        nota_feita = 1'b1; nota_correta = ok; tempo_correto = 1'b1; step();
        chk("st_toca_nota", 32'(db_estado), 32'h0B);
        chk("toca_press", 32'(toca), 32'd1);
        chk("registra_press", 32'(registra_nota), 32'd1);
        nota_feita = 1'b0; step();
        chk("st_compara", 32'(db_estado), 32'h0C);
        step();
        $display("note at endereco=%0d ok=%0d -> state=%0h pontos=%0d", endereco, ok, db_estado, pontos);
    endtask

    // From INICIO_NOTA: play notes 0..n correctly, ending in end_state
    task automatic play_round_ok(input int n, input logic [4:0] end_state);
        step();
        for (int i = 0; i <= n; i++) begin
            chk("st_espera_nota", 32'(db_estado), 32'h0A);
            chk("play_endereco", 32'(endereco), 32'(i));
            chk("play_vez", 32'(vez_jogador), 32'd1);
            press_note(1'b1);
            if (i < n) begin
                chk("st_prox_nota", 32'(db_estado), 32'h0D);
                step();
            end else begin
                chk("st_fim_rodada", 32'(db_estado), 32'h0E);
            end
        end
        step();
        chk("st_round_end", 32'(db_estado), 32'(end_state));
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_estado", 32'(db_estado), 32'h00);
        chk("rst_outputs", 32'(all_out), 32'h0);
        chk("rst_counters", 32'({endereco, rodada, tentativas, pontos}), 32'h0);
        reset = 1'b0; step();
        chk("idle_estado", 32'(db_estado), 32'h00);

        // Progressive mode, comprimento 2, all correct -> win with 6 points
        start_game(2'd0, 2'd1, 4'd2, 5'h05);
        chk("rodada_r0", 32'(rodada), 32'd0);
        show_round(0, 5'h09);
        play_round_ok(0, 5'h05);
        chk("rodada_r1", 32'(rodada), 32'd1);
        show_round(1, 5'h09);
        play_round_ok(1, 5'h05);
        chk("rodada_r2", 32'(rodada), 32'd2);
        show_round(2, 5'h09);
        play_round_ok(2, 5'h12);
        chk("win_pontos", 32'(pontos), 32'd6);
        chk("win_ganhou", 32'(ganhou), 32'd1);
        chk("win_menu_sel", 32'(menu_sel), 32'd3);
        $display("progressive game done state=%0h pontos=%0d", db_estado, pontos);

        // Policy 1: three wrong notes in round 0 -> loss
        press_enter = 1'b1; step(); press_enter = 1'b0;
        chk("back_inicial", 32'(db_estado), 32'h00);
        start_game(2'd0, 2'd1, 4'd2, 5'h05);
        show_round(0, 5'h09);
        step();
        for (int k = 1; k <= 3; k++) begin
            chk("st_wait_wrong", 32'(db_estado), 32'h0A);
            press_note(1'b0);
            chk("st_errou", 32'(db_estado), 32'h0F);
            chk("errou_zera_tempo", 32'(zera_tempo), 32'd1);
            step();
            if (k < 3) begin
                chk("st_inicio_nota_retry", 32'(db_estado), 32'h09);
                chk("tent_retry", 32'(tentativas), 32'(k));
                step();
            end else begin
                chk("st_perdeu", 32'(db_estado), 32'h11);
                chk("perdeu_flag", 32'(perdeu), 32'd1);
                chk("tent_final", 32'(tentativas), 32'd3);
            end
        end

        // Policy 2: wrong note at endereco 1 in round 1 -> show error, resume at 1
        press_enter = 1'b1; step(); press_enter = 1'b0;
        chk("back_inicial2", 32'(db_estado), 32'h00);
        start_game(2'd0, 2'd2, 4'd2, 5'h05);
        show_round(0, 5'h09);
        play_round_ok(0, 5'h05);
        show_round(1, 5'h09);
        step();
        press_note(1'b1);
        step();
        chk("pol2_endereco1", 32'(endereco), 32'd1);
        press_note(1'b0);
        chk("pol2_errou", 32'(db_estado), 32'h0F);
        step();
        chk("st_mostra_erro", 32'(db_estado), 32'h10);
        chk("mostra_erro_end", 32'(endereco), 32'd1);
        chk("mostra_erro_leds", 32'(leds_mem), 32'd1);
        chk("mostra_erro_tent", 32'(tentativas), 32'd1);
        fim_mostra = 1'b1; step(); fim_mostra = 1'b0;
        chk("resume_estado", 32'(db_estado), 32'h0A);
        chk("resume_endereco", 32'(endereco), 32'd1);

        // Timeout wins over a simultaneous key press
        fim_tempo = 1'b1; nota_feita = 1'b1; step();
        chk("timeout_errou", 32'(db_estado), 32'h0F);
        chk("timeout_no_toca", 32'(toca), 32'd0);
        fim_tempo = 1'b0; nota_feita = 1'b0; step();
        chk("timeout_mostra_erro", 32'(db_estado), 32'h10);
        chk("timeout_tent", 32'(tentativas), 32'd2);
        fim_mostra = 1'b1; step(); fim_mostra = 1'b0;
        press_note(1'b1);
        chk("r1_done", 32'(db_estado), 32'h0E);
        step();
        chk("r2_start", 32'(db_estado), 32'h05);
        chk("r2_tent_clear", 32'(tentativas), 32'd0);
        show_round(2, 5'h09);
        step();
        press_note(1'b1); step();
        press_note(1'b1); step();
        chk("pre_reset_estado", 32'(db_estado), 32'h0A);
        chk("pre_reset_endereco", 32'(endereco), 32'd2);
        chk("pre_reset_pontos", 32'(pontos), 32'd5);

        // Asynchronous reset mid-game, checked before any clock edge
        #2 reset = 1'b1; #1;
        chk("arst_estado", 32'(db_estado), 32'h00);
        chk("arst_endereco", 32'(endereco), 32'd0);
        chk("arst_pontos", 32'(pontos), 32'd0);
        chk("arst_outputs", 32'(all_out), 32'h0);
        step(); reset = 1'b0; step();

        // Demo mode, comprimento 3: loops the display, exit on press_enter
        start_game(2'd2, 2'd0, 4'd3, 5'h05);
        chk("demo_rodada", 32'(rodada), 32'd3);
        show_round(3, 5'h05);
        show_round(3, 5'h05);
        press_enter = 1'b1; step(); press_enter = 1'b0;
        chk("demo_exit", 32'(db_estado), 32'h00);

        // Free play: key press plays until release
        start_game(2'd3, 2'd0, 4'd0, 5'h13);
        nota_feita = 1'b1; step();
        chk("livre_toca_st", 32'(db_estado), 32'h14);
        chk("livre_toca1", 32'(toca), 32'd1);
        step();
        chk("livre_toca_held", 32'(toca), 32'd1);
        nota_feita = 1'b0; step();
        chk("livre_release_st", 32'(db_estado), 32'h13);
        chk("livre_release_toca", 32'(toca), 32'd0);
        press_enter = 1'b1; step(); press_enter = 1'b0;
        chk("livre_exit", 32'(db_estado), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
